// File: rtl/branch_rs_scheduler.sv
// Reservation station and issue scheduler for the branch/jump execution unit.
// Holds dispatched branch/JAL/JALR micro-ops, resolves pending operand tags
// from two CDB ports, and issues the lowest-index ready entry each cycle onto
// registered BranchRS_* outputs. A ROB misprediction flush empties the station.
module branch_rs_scheduler #(
   parameter int ENTRIES = 8,
   parameter int TAG_W   = 4,
   parameter int OP_W    = 6,
   parameter int DATA_W  = 32
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              rdy_in,
   input  logic              clear_in,
   input  logic              disp_valid,
   input  logic [OP_W-1:0]   disp_op,
   input  logic [DATA_W-1:0] disp_v1,
   input  logic [DATA_W-1:0] disp_v2,
   input  logic [TAG_W-1:0]  disp_q1,
   input  logic [TAG_W-1:0]  disp_q2,
   input  logic              disp_r1,
   input  logic              disp_r2,
   input  logic [TAG_W-1:0]  disp_dest,
   input  logic [DATA_W-1:0] disp_imm,
   input  logic [DATA_W-1:0] disp_pc,
   output logic              full_out,
   input  logic              cdb0_valid,
   input  logic [TAG_W-1:0]  cdb0_tag,
   input  logic [DATA_W-1:0] cdb0_data,
   input  logic              cdb1_valid,
   input  logic [TAG_W-1:0]  cdb1_tag,
   input  logic [DATA_W-1:0] cdb1_data,
   output logic              BranchRS_enable,
   output logic [OP_W-1:0]   BranchRS_op,
   output logic [DATA_W-1:0] BranchRS_reg1,
   output logic [DATA_W-1:0] BranchRS_reg2,
   output logic [TAG_W-1:0]  BranchRS_dest_rob,
   output logic [DATA_W-1:0] BranchRS_imm,
   output logic [DATA_W-1:0] BranchRS_pc
);
   localparam int IDX_W = $clog2(ENTRIES);

   localparam logic [1:0] ST_FREE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;

   logic [1:0]        state_q [ENTRIES];
   logic [1:0]        state_d [ENTRIES];
   logic              r1_q    [ENTRIES];
   logic              r1_d    [ENTRIES];
   logic              r2_q    [ENTRIES];
   logic              r2_d    [ENTRIES];
   logic [TAG_W-1:0]  q1_q    [ENTRIES];
   logic [TAG_W-1:0]  q1_d    [ENTRIES];
   logic [TAG_W-1:0]  q2_q    [ENTRIES];
   logic [TAG_W-1:0]  q2_d    [ENTRIES];
   logic [DATA_W-1:0] v1_q    [ENTRIES];
   logic [DATA_W-1:0] v1_d    [ENTRIES];
   logic [DATA_W-1:0] v2_q    [ENTRIES];
   logic [DATA_W-1:0] v2_d    [ENTRIES];
   logic [OP_W-1:0]   op_q    [ENTRIES];
   logic [OP_W-1:0]   op_d    [ENTRIES];
   logic [TAG_W-1:0]  dest_q  [ENTRIES];
   logic [TAG_W-1:0]  dest_d  [ENTRIES];
   logic [DATA_W-1:0] imm_q   [ENTRIES];
   logic [DATA_W-1:0] imm_d   [ENTRIES];
   logic [DATA_W-1:0] pc_q    [ENTRIES];
   logic [DATA_W-1:0] pc_d    [ENTRIES];

   logic              en_q,       en_d;
   logic [OP_W-1:0]   out_op_q,   out_op_d;
   logic [DATA_W-1:0] out_r1_q,   out_r1_d;
   logic [DATA_W-1:0] out_r2_q,   out_r2_d;
   logic [TAG_W-1:0]  out_dest_q, out_dest_d;
   logic [DATA_W-1:0] out_imm_q,  out_imm_d;
   logic [DATA_W-1:0] out_pc_q,   out_pc_d;

   logic              free_found;
   logic [IDX_W-1:0]  free_idx;
   logic              iss_found;
   logic [IDX_W-1:0]  iss_idx;

   // Find the lowest free slot and the lowest ready slot from registered state
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      iss_found  = 1'b0;
      iss_idx    = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (state_q[i] == ST_FREE) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (state_q[i] == ST_READY) begin
            iss_found = 1'b1;
            iss_idx   = IDX_W'(i);
         end
      end
   end

   assign full_out = ~free_found;

   // Next state: flush, then issue / wakeup / dispatch when not stalled
   always_comb begin
      state_d = state_q;
      r1_d    = r1_q;
      r2_d    = r2_q;
      q1_d    = q1_q;
      q2_d    = q2_q;
      v1_d    = v1_q;
      v2_d    = v2_q;
      op_d    = op_q;
      dest_d  = dest_q;
      imm_d   = imm_q;
      pc_d    = pc_q;

      en_d       = 1'b0;
      out_op_d   = '0;
      out_r1_d   = '0;
      out_r2_d   = '0;
      out_dest_d = '0;
      out_imm_d  = '0;
      out_pc_d   = '0;

      if (clear_in) begin
         for (int i = 0; i < ENTRIES; i++) state_d[i] = ST_FREE;
      end else if (rdy_in) begin
         // The issued slot stays non-free until the edge, so dispatch never picks it
         if (iss_found) begin
            en_d             = 1'b1;
            out_op_d         = op_q[iss_idx];
            out_r1_d         = v1_q[iss_idx];
            out_r2_d         = v2_q[iss_idx];
            out_dest_d       = dest_q[iss_idx];
            out_imm_d        = imm_q[iss_idx];
            out_pc_d         = pc_q[iss_idx];
            state_d[iss_idx] = ST_FREE;
         end

         for (int i = 0; i < ENTRIES; i++) begin
            if (state_q[i] == ST_WAIT) begin
               if (!r1_q[i]) begin
                  if (cdb0_valid && cdb0_tag == q1_q[i]) begin
                     v1_d[i] = cdb0_data;
                     r1_d[i] = 1'b1;
                  end else if (cdb1_valid && cdb1_tag == q1_q[i]) begin
                     v1_d[i] = cdb1_data;
                     r1_d[i] = 1'b1;
                  end
               end
               if (!r2_q[i]) begin
                  if (cdb0_valid && cdb0_tag == q2_q[i]) begin
                     v2_d[i] = cdb0_data;
                     r2_d[i] = 1'b1;
                  end else if (cdb1_valid && cdb1_tag == q2_q[i]) begin
                     v2_d[i] = cdb1_data;
                     r2_d[i] = 1'b1;
                  end
               end
               if (r1_d[i] && r2_d[i]) state_d[i] = ST_READY;
            end
         end

         if (disp_valid && free_found) begin
            op_d[free_idx]   = disp_op;
            dest_d[free_idx] = disp_dest;
            imm_d[free_idx]  = disp_imm;
            pc_d[free_idx]   = disp_pc;
            q1_d[free_idx]   = disp_q1;
            q2_d[free_idx]   = disp_q2;
            v1_d[free_idx]   = disp_v1;
            v2_d[free_idx]   = disp_v2;
            r1_d[free_idx]   = disp_r1;
            r2_d[free_idx]   = disp_r2;
            if (!disp_r1) begin
               if (cdb0_valid && cdb0_tag == disp_q1) begin
                  v1_d[free_idx] = cdb0_data;
                  r1_d[free_idx] = 1'b1;
               end else if (cdb1_valid && cdb1_tag == disp_q1) begin
                  v1_d[free_idx] = cdb1_data;
                  r1_d[free_idx] = 1'b1;
               end
            end
            if (!disp_r2) begin
               if (cdb0_valid && cdb0_tag == disp_q2) begin
                  v2_d[free_idx] = cdb0_data;
                  r2_d[free_idx] = 1'b1;
               end else if (cdb1_valid && cdb1_tag == disp_q2) begin
                  v2_d[free_idx] = cdb1_data;
                  r2_d[free_idx] = 1'b1;
               end
            end
            state_d[free_idx] = (r1_d[free_idx] && r2_d[free_idx]) ? ST_READY : ST_WAIT;
         end
      end
   end

   // Slot occupancy and issue outputs, returned to idle by async reset
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= '{default: ST_FREE};
         en_q       <= 1'b0;
         out_op_q   <= '0;
         out_r1_q   <= '0;
         out_r2_q   <= '0;
         out_dest_q <= '0;
         out_imm_q  <= '0;
         out_pc_q   <= '0;
      end else begin
         state_q    <= state_d;
         en_q       <= en_d;
         out_op_q   <= out_op_d;
         out_r1_q   <= out_r1_d;
         out_r2_q   <= out_r2_d;
         out_dest_q <= out_dest_d;
         out_imm_q  <= out_imm_d;
         out_pc_q   <= out_pc_d;
      end
   end

   // Slot payload; only read while the slot is occupied, so it needs no reset
   always_ff @(posedge clk_in) begin
      r1_q   <= r1_d;
      r2_q   <= r2_d;
      q1_q   <= q1_d;
      q2_q   <= q2_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      op_q   <= op_d;
      dest_q <= dest_d;
      imm_q  <= imm_d;
      pc_q   <= pc_d;
   end

   assign BranchRS_enable   = en_q;
   assign BranchRS_op       = out_op_q;
   assign BranchRS_reg1     = out_r1_q;
   assign BranchRS_reg2     = out_r2_q;
   assign BranchRS_dest_rob = out_dest_q;
   assign BranchRS_imm      = out_imm_q;
   assign BranchRS_pc       = out_pc_q;

endmodule

// File: tb/tb_branch_rs_scheduler.sv
// Testbench for branch_rs_scheduler: directed scenarios followed by a
// randomized run against a slot-list reference model.
module tb_branch_rs_scheduler;
   localparam int ENTRIES = 8;
   localparam int TAG_W   = 4;
   localparam int OP_W    = 6;
   localparam int DATA_W  = 32;
   localparam int BUS_W   = 1 + OP_W + 4 * DATA_W + TAG_W;

   logic              clk_in = 1'b0;
   logic              rst_n_in;
   logic              rdy_in;
   logic              clear_in;
   logic              disp_valid;
   logic [OP_W-1:0]   disp_op;
   logic [DATA_W-1:0] disp_v1, disp_v2;
   logic [TAG_W-1:0]  disp_q1, disp_q2;
   logic              disp_r1, disp_r2;
   logic [TAG_W-1:0]  disp_dest;
   logic [DATA_W-1:0] disp_imm, disp_pc;
   logic              full_out;
   logic              cdb0_valid, cdb1_valid;
   logic [TAG_W-1:0]  cdb0_tag, cdb1_tag;
   logic [DATA_W-1:0] cdb0_data, cdb1_data;
   logic              BranchRS_enable;
   logic [OP_W-1:0]   BranchRS_op;
   logic [DATA_W-1:0] BranchRS_reg1, BranchRS_reg2;
   logic [TAG_W-1:0]  BranchRS_dest_rob;
   logic [DATA_W-1:0] BranchRS_imm, BranchRS_pc;

   logic [BUS_W-1:0]  out_bus;
   assign out_bus = {BranchRS_enable, BranchRS_op, BranchRS_reg1, BranchRS_reg2,
                     BranchRS_dest_rob, BranchRS_imm, BranchRS_pc};

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit                busy;
      bit                r1;
      bit                r2;
      logic [TAG_W-1:0]  q1;
      logic [TAG_W-1:0]  q2;
      logic [TAG_W-1:0]  dest;
      logic [DATA_W-1:0] v1;
      logic [DATA_W-1:0] v2;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc;
      logic [OP_W-1:0]   op;
   } ent_t;

   ent_t model [ENTRIES];

   always #5 clk_in = ~clk_in;

   branch_rs_scheduler #(
      .ENTRIES(ENTRIES), .TAG_W(TAG_W), .OP_W(OP_W), .DATA_W(DATA_W)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
      .disp_valid(disp_valid), .disp_op(disp_op), .disp_v1(disp_v1), .disp_v2(disp_v2),
      .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_r1(disp_r1), .disp_r2(disp_r2),
      .disp_dest(disp_dest), .disp_imm(disp_imm), .disp_pc(disp_pc), .full_out(full_out),
      .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
      .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
      .BranchRS_enable(BranchRS_enable), .BranchRS_op(BranchRS_op),
      .BranchRS_reg1(BranchRS_reg1), .BranchRS_reg2(BranchRS_reg2),
      .BranchRS_dest_rob(BranchRS_dest_rob), .BranchRS_imm(BranchRS_imm),
      .BranchRS_pc(BranchRS_pc)
   );

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle();
      rdy_in = 1'b1; clear_in = 1'b0; disp_valid = 1'b0;
      disp_op = '0; disp_v1 = '0; disp_v2 = '0; disp_q1 = '0; disp_q2 = '0;
      disp_r1 = 1'b0; disp_r2 = 1'b0; disp_dest = '0; disp_imm = '0; disp_pc = '0;
      cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_data = '0;
      cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_data = '0;
   endtask

   task automatic set_disp(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] v1,
                           input logic [DATA_W-1:0] v2, input logic [TAG_W-1:0] q1,
                           input logic [TAG_W-1:0] q2, input logic r1, input logic r2,
                           input logic [TAG_W-1:0] dest, input logic [DATA_W-1:0] imm,
                           input logic [DATA_W-1:0] pc);
      disp_valid = 1'b1; disp_op = op; disp_v1 = v1; disp_v2 = v2; disp_q1 = q1;
      disp_q2 = q2; disp_r1 = r1; disp_r2 = r2; disp_dest = dest; disp_imm = imm;
      disp_pc = pc;
   endtask

   task automatic test_reset();
      idle();
      rst_n_in = 1'b0;
      tick();
      tick();
      checks++;
      if (out_bus !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", out_bus); end
      checks++;
      if (full_out !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full_out); end
      rst_n_in = 1'b1;
      tick();
   endtask

   task automatic test_ready_dispatch();
      set_disp(6'd1, 32'd5, 32'd5, 4'd0, 4'd0, 1'b1, 1'b1, 4'd3, 32'd8, 32'h100);
      tick();
      idle();
      checks++;
      if (BranchRS_enable !== 1'b0) begin errors++; $display("FAIL ready_early got %b want 0", BranchRS_enable); end
      tick();
      checks++;
      if (out_bus !== {1'b1, 6'd1, 32'd5, 32'd5, 4'd3, 32'd8, 32'h100}) begin
         errors++; $display("FAIL ready_issue got %h want BEQ fields", out_bus);
      end
      tick();
      checks++;
      if (out_bus !== '0) begin errors++; $display("FAIL ready_after got %h want 0", out_bus); end
   endtask

   task automatic test_cdb_wakeup();
      set_disp(6'd2, 32'd0, 32'd1, 4'd7, 4'd0, 1'b0, 1'b1, 4'd4, 32'd12, 32'h104);
      tick();
      idle();
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (BranchRS_enable !== 1'b0) begin errors++; $display("FAIL wake_hold%0d got %b want 0", k, BranchRS_enable); end
      end
      cdb1_valid = 1'b1; cdb1_tag = 4'd7; cdb1_data = 32'd9;
      tick();
      idle();
      checks++;
      if (BranchRS_enable !== 1'b0) begin errors++; $display("FAIL wake_early got %b want 0", BranchRS_enable); end
      tick();
      checks++;
      if (out_bus !== {1'b1, 6'd2, 32'd9, 32'd1, 4'd4, 32'd12, 32'h104}) begin
         errors++; $display("FAIL wake_issue got %h want reg1=9 reg2=1", out_bus);
      end
      tick();
   endtask

   task automatic test_forward();
      set_disp(6'd3, 32'd0, 32'h33, 4'd2, 4'd0, 1'b0, 1'b1, 4'd5, 32'd0, 32'h108);
      cdb0_valid = 1'b1; cdb0_tag = 4'd2; cdb0_data = 32'h55;
      cdb1_valid = 1'b1; cdb1_tag = 4'd2; cdb1_data = 32'h66;
      tick();
      idle();
      tick();
      checks++;
      if (out_bus !== {1'b1, 6'd3, 32'h55, 32'h33, 4'd5, 32'd0, 32'h108}) begin
         errors++; $display("FAIL forward_issue got %h want reg1=55", out_bus);
      end
      tick();
   endtask

   task automatic test_full();
      for (int k = 0; k < ENTRIES; k++) begin
         set_disp(6'd2, 32'd0, 32'h100 + k, 4'd1, 4'd0, 1'b0, 1'b1, TAG_W'(k), k, 32'h200 + 4 * k);
         tick();
      end
      idle();
      checks++;
      if (full_out !== 1'b1) begin errors++; $display("FAIL full_set got %b want 1", full_out); end
      set_disp(6'd9, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd15, 32'd0, 32'h0);
      tick();
      idle();
      checks++;
      if (full_out !== 1'b1 || BranchRS_enable !== 1'b0) begin
         errors++; $display("FAIL full_ignore got full=%b en=%b want full=1 en=0", full_out, BranchRS_enable);
      end
      cdb0_valid = 1'b1; cdb0_tag = 4'd1; cdb0_data = 32'hAB;
      tick();
      idle();
      checks++;
      if (full_out !== 1'b1 || BranchRS_enable !== 1'b0) begin
         errors++; $display("FAIL full_capture got full=%b en=%b want full=1 en=0", full_out, BranchRS_enable);
      end
      for (int k = 0; k < ENTRIES; k++) begin
         tick();
         checks++;
         if (out_bus !== {1'b1, 6'd2, 32'hAB, 32'h100 + k, TAG_W'(k), k, 32'h200 + 4 * k}) begin
            errors++; $display("FAIL full_order%0d got %h want slot %0d", k, out_bus, k);
         end
         if (k == 0) begin
            checks++;
            if (full_out !== 1'b0) begin errors++; $display("FAIL full_drop got %b want 0", full_out); end
         end
      end
      tick();
      checks++;
      if (out_bus !== '0) begin errors++; $display("FAIL full_drained got %h want 0", out_bus); end
   endtask

   task automatic test_clear();
      for (int k = 0; k < 3; k++) begin
         set_disp(6'd4, 32'd0, 32'd0, 4'd9, 4'd9, 1'b0, 1'b0, TAG_W'(k), 32'd0, 32'h300);
         tick();
      end
      set_disp(6'd4, 32'd1, 32'd2, 4'd0, 4'd0, 1'b1, 1'b1, 4'd4, 32'd0, 32'h310);
      tick();
      set_disp(6'd5, 32'd3, 32'd4, 4'd0, 4'd0, 1'b1, 1'b1, 4'd12, 32'd0, 32'h320);
      clear_in = 1'b1;
      tick();
      idle();
      checks++;
      if (out_bus !== '0 || full_out !== 1'b0) begin
         errors++; $display("FAIL clear_cycle got %h full=%b want 0 full=0", out_bus, full_out);
      end
      tick();
      checks++;
      if (out_bus !== '0) begin errors++; $display("FAIL clear_dropped got %h want 0", out_bus); end
      cdb0_valid = 1'b1; cdb0_tag = 4'd9; cdb0_data = 32'h1;
      tick();
      idle();
      tick();
      checks++;
      if (out_bus !== '0) begin errors++; $display("FAIL clear_empty got %h want 0", out_bus); end
   endtask

   task automatic test_stall();
      set_disp(6'd3, 32'd11, 32'd22, 4'd0, 4'd0, 1'b1, 1'b1, 4'd5, 32'd7, 32'h400);
      tick();
      idle();
      rdy_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (out_bus !== '0) begin errors++; $display("FAIL stall_hold%0d got %h want 0", k, out_bus); end
      end
      rdy_in = 1'b1;
      tick();
      checks++;
      if (out_bus !== {1'b1, 6'd3, 32'd11, 32'd22, 4'd5, 32'd7, 32'h400}) begin
         errors++; $display("FAIL stall_resume got %h want dest 5", out_bus);
      end
      set_disp(6'd6, 32'd0, 32'd3, 4'd4, 4'd0, 1'b0, 1'b1, 4'd6, 32'd0, 32'h410);
      tick();
      idle();
      rdy_in = 1'b0;
      cdb0_valid = 1'b1; cdb0_tag = 4'd4; cdb0_data = 32'h77;
      tick();
      idle();
      tick();
      tick();
      checks++;
      if (out_bus !== '0) begin errors++; $display("FAIL stall_cdb got %h want 0", out_bus); end
      cdb0_valid = 1'b1; cdb0_tag = 4'd4; cdb0_data = 32'h88;
      tick();
      idle();
      tick();
      checks++;
      if (out_bus !== {1'b1, 6'd6, 32'h88, 32'd3, 4'd6, 32'd0, 32'h410}) begin
         errors++; $display("FAIL stall_rebroadcast got %h want reg1=88", out_bus);
      end
      tick();
   endtask

   task automatic test_async_reset();
      set_disp(6'd7, 32'd1, 32'd2, 4'd0, 4'd0, 1'b1, 1'b1, 4'd6, 32'd0, 32'h500);
      tick();
      set_disp(6'd7, 32'd3, 32'd4, 4'd0, 4'd0, 1'b1, 1'b1, 4'd7, 32'd0, 32'h504);
      tick();
      idle();
      checks++;
      if (out_bus !== {1'b1, 6'd7, 32'd1, 32'd2, 4'd6, 32'd0, 32'h500}) begin
         errors++; $display("FAIL b2b_first got %h want dest 6", out_bus);
      end
      #2;
      rst_n_in = 1'b0;
      #1;
      checks++;
      if (out_bus !== '0 || full_out !== 1'b0) begin
         errors++; $display("FAIL async_reset got %h full=%b want 0", out_bus, full_out);
      end
      @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;
      tick();
      tick();
      checks++;
      if (out_bus !== '0) begin errors++; $display("FAIL async_entries got %h want 0", out_bus); end
   endtask

   function automatic logic [DATA_W:0] cdb_lookup(input logic [TAG_W-1:0] t);
      if (cdb0_valid && cdb0_tag == t) return {1'b1, cdb0_data};
      if (cdb1_valid && cdb1_tag == t) return {1'b1, cdb1_data};
      return '0;
   endfunction

   task automatic test_random();
      ent_t              snap [ENTRIES];
      ent_t              e;
      logic [BUS_W-1:0]  exp_bus;
      logic [DATA_W:0]   hit;
      logic              exp_full;
      int                iss;
      int                fre;
      idle();
      rst_n_in = 1'b0;
      tick();
      rst_n_in = 1'b1;
      for (int i = 0; i < ENTRIES; i++) model[i].busy = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         rdy_in     = ($urandom_range(0, 7) != 0);
         clear_in   = ($urandom_range(0, 63) == 0);
         disp_valid = $urandom_range(0, 1) == 1;
         disp_op    = OP_W'($urandom);
         disp_v1    = $urandom;
         disp_v2    = $urandom;
         disp_q1    = TAG_W'($urandom);
         disp_q2    = TAG_W'($urandom);
         disp_r1    = $urandom_range(0, 1) == 1;
         disp_r2    = $urandom_range(0, 1) == 1;
         disp_dest  = TAG_W'($urandom);
         disp_imm   = $urandom;
         disp_pc    = $urandom;
         cdb0_valid = $urandom_range(0, 9) < 4;
         cdb0_tag   = TAG_W'($urandom);
         cdb0_data  = $urandom;
         cdb1_valid = $urandom_range(0, 9) < 4;
         cdb1_tag   = TAG_W'($urandom);
         cdb1_data  = $urandom;

         snap    = model;
         exp_bus = '0;
         if (clear_in) begin
            for (int i = 0; i < ENTRIES; i++) model[i].busy = 1'b0;
         end else if (rdy_in) begin
            iss = -1;
            fre = -1;
            for (int i = 0; i < ENTRIES; i++) begin
               if (iss < 0 && snap[i].busy && snap[i].r1 && snap[i].r2) iss = i;
               if (fre < 0 && !snap[i].busy) fre = i;
            end
            if (iss >= 0) begin
               exp_bus = {1'b1, snap[iss].op, snap[iss].v1, snap[iss].v2,
                          snap[iss].dest, snap[iss].imm, snap[iss].pc};
               model[iss].busy = 1'b0;
            end
            for (int i = 0; i < ENTRIES; i++) begin
               if (snap[i].busy && i != iss) begin
                  if (!model[i].r1) begin
                     hit = cdb_lookup(model[i].q1);
                     if (hit[DATA_W]) begin model[i].r1 = 1'b1; model[i].v1 = hit[DATA_W-1:0]; end
                  end
                  if (!model[i].r2) begin
                     hit = cdb_lookup(model[i].q2);
                     if (hit[DATA_W]) begin model[i].r2 = 1'b1; model[i].v2 = hit[DATA_W-1:0]; end
                  end
               end
            end
            if (disp_valid && fre >= 0) begin
               e.busy = 1'b1; e.op = disp_op; e.dest = disp_dest; e.imm = disp_imm;
               e.pc = disp_pc; e.q1 = disp_q1; e.q2 = disp_q2;
               e.r1 = disp_r1; e.v1 = disp_v1; e.r2 = disp_r2; e.v2 = disp_v2;
               if (!disp_r1) begin
                  hit = cdb_lookup(disp_q1);
                  if (hit[DATA_W]) begin e.r1 = 1'b1; e.v1 = hit[DATA_W-1:0]; end
               end
               if (!disp_r2) begin
                  hit = cdb_lookup(disp_q2);
                  if (hit[DATA_W]) begin e.r2 = 1'b1; e.v2 = hit[DATA_W-1:0]; end
               end
               model[fre] = e;
            end
         end
         exp_full = 1'b1;
         for (int i = 0; i < ENTRIES; i++) if (!model[i].busy) exp_full = 1'b0;

         tick();
         checks++;
         if (out_bus !== exp_bus) begin
            errors++; $display("FAIL rand_issue cyc %0d got %h want %h", n, out_bus, exp_bus);
         end
         checks++;
         if (full_out !== exp_full) begin
            errors++; $display("FAIL rand_full cyc %0d got %b want %b", n, full_out, exp_full);
         end
      end
      idle();
   endtask

   initial begin
      rst_n_in = 1'b0;
      idle();
      test_reset();
      test_ready_dispatch();
      test_cdb_wakeup();
      test_forward();
      test_full();
      test_clear();
      test_stall();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
